// File: rtl/dlfloat_result_streamer.sv
// dlfloat_result_streamer: FIFO-buffered DLFloat16 result serializer, MSB byte first, valid/ready output.
// Optional DLF_SPECIAL_FLAG_EN adds out_special {all-ones, all-zeros} flags aligned with out_byte.
module dlfloat_result_streamer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef DLF_SPECIAL_FLAG_EN
  ,
  output logic [1:0]        out_special
`endif
);
  typedef enum logic [1:0] {IDLE, MSB, LSB} state_t;
  state_t            r_state;
  logic [15:0]       r_mem [DEPTH];
  logic [15:0]       r_hold;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push, w_pop;
  logic [15:0]       w_head;
  assign in_ready   = r_count != (ADDR_W+1)'(DEPTH);
  assign fifo_count = r_count;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push     = in_valid & in_ready;
  // LSB acceptance chains straight into the next word so the stream has no bubble
  assign w_pop      = (r_count != '0) & ((r_state == IDLE) | ((r_state == LSB) & out_ready));
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
`ifdef DLF_SPECIAL_FLAG_EN
      out_special <= '0;
`endif
    end else begin
      r_count  <= r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};
      overflow <= (in_valid & ~in_ready) | (overflow & ~clr_ovf);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_hold    <= w_head;
        out_byte  <= w_head[15:8];
        out_last  <= 1'b0;
        out_valid <= 1'b1;
        r_state   <= MSB;
`ifdef DLF_SPECIAL_FLAG_EN
        out_special <= {w_head == 16'hFFFF, w_head == 16'h0000};
`endif
      end else if (r_state == MSB && out_ready) begin
        out_byte <= r_hold[7:0];
        out_last <= 1'b1;
        r_state  <= LSB;
      end else if (r_state == LSB && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        r_state   <= IDLE;
`ifdef DLF_SPECIAL_FLAG_EN
        out_special <= '0;
`endif
      end
    end
  end
endmodule
